// File: rtl/modport_addr_hub.sv
// ============================================================================
// Module   : modport_addr_hub
// Brief    : Holds one address per output port, flags it pending until acked,
//            and drops/counts misaligned or out-of-range requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modport_addr_hub #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_PORTS  = 2,
    parameter int ALIGN_BITS = 2,
    localparam int c_sel_width = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ADDR_WIDTH-1:0]            in_addr,
    input  logic [c_sel_width-1:0]           in_sel,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0]  out_addr,
    output logic [NUM_PORTS-1:0]             out_pending,
    input  logic [NUM_PORTS-1:0]             out_ack,
    output logic                             err_pulse,
    output logic [7:0]                       err_count
);

    localparam int                 c_sel_span  = 2 ** c_sel_width;
    localparam logic [c_sel_width:0] c_num_ports = (c_sel_width + 1)'(NUM_PORTS);

    logic [ADDR_WIDTH-1:0] r_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0]  r_pending;
    logic                  r_err_pulse;
    logic [7:0]            r_err_count;

    logic                  w_sel_oob;
    logic                  w_misaligned;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_accept_legal;
    logic                  w_accept_illegal;
    logic [c_sel_span-1:0] w_busy;
    logic [NUM_PORTS-1:0]  w_wr;

    assign w_sel_oob = ({1'b0, in_sel} >= c_num_ports);

    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign w_misaligned = |in_addr[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign w_misaligned = 1'b0;
        end
    endgenerate

    assign w_illegal = w_sel_oob | w_misaligned;

    // Busy vector padded to the full select span so in_sel can index it safely
    generate
        for (genvar p = 0; p < c_sel_span; p++) begin : g_busy
            if (p < NUM_PORTS) begin : g_real
                assign w_busy[p] = r_pending[p] & ~out_ack[p];
            end else begin : g_pad
                assign w_busy[p] = 1'b0;
            end
        end
    endgenerate

    assign in_ready         = rst_n & (w_illegal | ~w_busy[in_sel]);
    assign w_accept         = in_valid & in_ready;
    assign w_accept_legal   = w_accept & ~w_illegal;
    assign w_accept_illegal = w_accept & w_illegal;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign w_wr[p] = w_accept_legal && (in_sel == c_sel_width'(p));
            assign out_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = r_addr[p];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_addr[p] <= '0;
            end
            r_pending   <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            // A new write wins over a same-edge ack, keeping the port pending
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_wr[p]) begin
                    r_addr[p]    <= in_addr;
                    r_pending[p] <= 1'b1;
                end else if (out_ack[p]) begin
                    r_pending[p] <= 1'b0;
                end
            end
            r_err_pulse <= w_accept_illegal;
            if (w_accept_illegal && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign out_pending = r_pending;
    assign err_pulse   = r_err_pulse;
    assign err_count   = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_modport_addr_hub.sv
// ============================================================================
// Module   : tb_modport_addr_hub
// Brief    : Directed and randomized checks of modport_addr_hub against a
//            behavioural per-port model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modport_addr_hub;

    localparam int AW = 32;
    localparam int NP = 2;
    localparam int AB = 2;
    localparam int SW = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [AW-1:0]     in_addr = '0;
    logic [SW-1:0]     in_sel = '0;
    logic [NP*AW-1:0]  out_addr;
    logic [NP-1:0]     out_pending;
    logic [NP-1:0]     out_ack = '0;
    logic              err_pulse;
    logic [7:0]        err_count;

    modport_addr_hub #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .ALIGN_BITS(AB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_sel     (in_sel),
        .out_addr   (out_addr),
        .out_pending(out_pending),
        .out_ack    (out_ack),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: held address and pending flag per port, error tally
    logic [AW-1:0] m_addr [NP];
    logic [NP-1:0] m_pend = '0;
    logic          m_pulse = 1'b0;
    int            m_count = 0;
    logic          got_ready;
    logic          exp_ready;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [NP*AW-1:0] exp_addr_vec();
        logic [NP*AW-1:0] v;
        for (int p = 0; p < NP; p++) v[p*AW +: AW] = m_addr[p];
        return v;
    endfunction

    // Drives one cycle of stimulus, samples in_ready, advances model and DUT
    task automatic cycle(input logic v, input logic [AW-1:0] a, input int sel,
                         input logic [NP-1:0] ack);
        logic illegal;
        @(negedge clk);
        in_valid = v;
        in_addr  = a;
        in_sel   = SW'(sel);
        out_ack  = ack;
        #1;
        got_ready = in_ready;
        illegal   = (sel >= NP) || (a[AB-1:0] != '0);
        exp_ready = rst_n && (illegal || !m_pend[sel] || ack[sel]);
        @(posedge clk);
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) m_addr[p] = '0;
            m_pend  = '0;
            m_pulse = 1'b0;
            m_count = 0;
        end else begin
            m_pulse = 1'b0;
            for (int p = 0; p < NP; p++) if (ack[p]) m_pend[p] = 1'b0;
            if (v && exp_ready) begin
                if (illegal) begin
                    m_pulse = 1'b1;
                    if (m_count < 255) m_count++;
                end else begin
                    m_addr[sel] = a;
                    m_pend[sel] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b1, 32'h0, 0, '0);
        n_checks++; if (got_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", got_ready); else n_pass++;
        cycle(1'b0, 32'h0, 0, '0);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 32'h0, 0, '0);
        n_checks++; if (out_addr !== '0) $display("FAIL reset_addr got=%h want=0", out_addr); else n_pass++;
        n_checks++; if (out_pending !== 2'b00) $display("FAIL reset_pending got=%b want=00", out_pending); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL reset_errcnt got=%0d want=0", err_count); else n_pass++;
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL reset_errpulse got=%b want=0", err_pulse); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_idle_ready got=%b want=1", in_ready); else n_pass++;
    endtask

    task automatic test_single_write();
        cycle(1'b1, 32'h0000_1000, 0, '0);
        n_checks++; if (got_ready !== 1'b1) $display("FAIL wr_ready got=%b want=1", got_ready); else n_pass++;
        n_checks++; if (out_addr[31:0] !== 32'h0000_1000) $display("FAIL wr_addr0 got=%h want=00001000", out_addr[31:0]); else n_pass++;
        n_checks++; if (out_pending !== 2'b01) $display("FAIL wr_pending got=%b want=01", out_pending); else n_pass++;
        cycle(1'b1, 32'h0000_3000, 0, '0);
        n_checks++; if (got_ready !== 1'b0) $display("FAIL wr_blocked_ready got=%b want=0", got_ready); else n_pass++;
        n_checks++; if (out_addr[31:0] !== 32'h0000_1000) $display("FAIL wr_blocked_addr got=%h want=00001000", out_addr[31:0]); else n_pass++;
        cycle(1'b0, 32'h0, 0, 2'b01);
        n_checks++; if (out_pending !== 2'b00) $display("FAIL wr_ack_clear got=%b want=00", out_pending); else n_pass++;
    endtask

    task automatic test_ack_hold();
        cycle(1'b1, 32'hDEAD_BEE0, 1, '0);
        n_checks++; if (out_pending !== 2'b10) $display("FAIL hold_pending got=%b want=10", out_pending); else n_pass++;
        cycle(1'b0, 32'h0, 0, 2'b10);
        n_checks++; if (out_pending[1] !== 1'b0) $display("FAIL hold_ack got=%b want=0", out_pending[1]); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 0, '0);
            n_checks++; if (out_addr[63:32] !== 32'hDEAD_BEE0) $display("FAIL hold_addr1 cyc=%0d got=%h want=deadbee0", i, out_addr[63:32]); else n_pass++;
        end
    endtask

    task automatic test_ack_with_request();
        cycle(1'b1, 32'h0000_1000, 0, '0);
        cycle(1'b1, 32'h0000_2000, 0, 2'b01);
        n_checks++; if (got_ready !== 1'b1) $display("FAIL ackreq_ready got=%b want=1", got_ready); else n_pass++;
        n_checks++; if (out_addr[31:0] !== 32'h0000_2000) $display("FAIL ackreq_addr got=%h want=00002000", out_addr[31:0]); else n_pass++;
        n_checks++; if (out_pending[0] !== 1'b1) $display("FAIL ackreq_pending got=%b want=1", out_pending[0]); else n_pass++;
    endtask

    task automatic test_errors();
        cycle(1'b1, 32'h0000_1002, 0, '0);
        n_checks++; if (got_ready !== 1'b1) $display("FAIL err_ready got=%b want=1", got_ready); else n_pass++;
        n_checks++; if (out_addr[31:0] !== 32'h0000_2000) $display("FAIL err_addr_kept got=%h want=00002000", out_addr[31:0]); else n_pass++;
        n_checks++; if (err_pulse !== 1'b1) $display("FAIL err_pulse got=%b want=1", err_pulse); else n_pass++;
        n_checks++; if (err_count !== 8'd1) $display("FAIL err_count got=%0d want=1", err_count); else n_pass++;
        cycle(1'b0, 32'h0, 0, '0);
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL err_pulse_drop got=%b want=0", err_pulse); else n_pass++;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 32'h0000_1001 + 32'(i << 2), i % NP, '0);
            n_checks++; if (err_pulse !== 1'b1) $display("FAIL err_b2b_pulse cyc=%0d got=%b want=1", i, err_pulse); else n_pass++;
        end
        n_checks++; if (err_count !== 8'd255) $display("FAIL err_saturate got=%0d want=255", err_count); else n_pass++;
        n_checks++; if (out_pending !== m_pend) $display("FAIL err_pending_kept got=%b want=%b", out_pending, m_pend); else n_pass++;
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 32'h0, 0, 2'b11);
        cycle(1'b1, 32'h0000_4000, 0, '0);
        cycle(1'b1, 32'h0000_5000, 1, '0);
        n_checks++; if (out_pending !== 2'b11) $display("FAIL rstmid_pre got=%b want=11", out_pending); else n_pass++;
        rst_n = 1'b0;
        cycle(1'b0, 32'h0, 0, '0);
        rst_n = 1'b1;
        n_checks++; if (out_pending !== 2'b00) $display("FAIL rstmid_pending got=%b want=00", out_pending); else n_pass++;
        n_checks++; if (out_addr !== '0) $display("FAIL rstmid_addr got=%h want=0", out_addr); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL rstmid_errcnt got=%0d want=0", err_count); else n_pass++;
    endtask

    task automatic test_random();
        logic          v;
        logic [AW-1:0] a;
        int            sel;
        logic [NP-1:0] ack;
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[AB-1:0] = '0;
            sel = $urandom_range(0, NP - 1);
            ack = NP'($urandom_range(0, (1 << NP) - 1));
            cycle(v, a, sel, ack);
            n_checks++; if (got_ready !== exp_ready) $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, got_ready, exp_ready); else n_pass++;
            n_checks++; if (out_addr !== exp_addr_vec()) $display("FAIL rnd_addr cyc=%0d got=%h want=%h", i, out_addr, exp_addr_vec()); else n_pass++;
            n_checks++; if (out_pending !== m_pend) $display("FAIL rnd_pending cyc=%0d got=%b want=%b", i, out_pending, m_pend); else n_pass++;
            n_checks++; if (err_pulse !== m_pulse) $display("FAIL rnd_errpulse cyc=%0d got=%b want=%b", i, err_pulse, m_pulse); else n_pass++;
            n_checks++; if (err_count !== 8'(m_count)) $display("FAIL rnd_errcnt cyc=%0d got=%0d want=%0d", i, err_count, m_count); else n_pass++;
        end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) m_addr[p] = '0;
        test_reset();
        test_single_write();
        test_ack_hold();
        test_ack_with_request();
        test_errors();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/modport_addr_hub.md
Name: modport_addr_hub

Overview:
- Single-clock hub that distributes 32-bit addresses to NUM_PORTS "source"-style address interfaces.
- Each output port carries a held address, the way an interface modport exposes an addr input to a consumer.
- Upstream producers hand over one address per valid/ready transfer together with a port select; the hub holds the address per port and flags it pending until that port's consumer acknowledges it.
- Misaligned or out-of-range requests are accepted and dropped, and counted as errors.

Parameters:
- ADDR_WIDTH, 32, width of every address bus.
- NUM_PORTS, 2, number of output address ports (legal range 2..8).
- ALIGN_BITS, 2, number of low address bits that must be zero for a request to be legal (0 disables the check).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  request valid.
- in_ready  output  1  hub can accept the request this cycle.
- in_addr  input  ADDR_WIDTH  requested address.
- in_sel  input  max(1,$clog2(NUM_PORTS))  target port index.
- out_addr  output  NUM_PORTS*ADDR_WIDTH  held address per port; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- out_pending  output  NUM_PORTS  port p holds an address not yet acknowledged.
- out_ack  input  NUM_PORTS  consumer p acknowledges its pending address.
- err_pulse  output  1  one-cycle pulse for each dropped request.
- err_count  output  8  saturating count of dropped requests.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: out_addr all 0, out_pending all 0, err_pulse 0, err_count 0.
  - While rst_n=0, in_ready=0.
  - Reset mid-operation discards all pending addresses. No ack is required afterwards.
- Transfer occurs on a rising edge where in_valid=1 and in_ready=1.
- in_ready (combinational):
  - 1 if in_sel is out of range, or if the request is misaligned (these are always accepted).
  - Otherwise 1 only if out_pending[in_sel]=0 or out_ack[in_sel]=1.
  - Combinational on in_sel, out_pending and out_ack; no dependence on in_valid.
- A request is illegal if in_sel >= NUM_PORTS, or if ALIGN_BITS>0 and in_addr[ALIGN_BITS-1:0] != 0.
- Legal accepted request to port p:
  - out_addr[p] <= in_addr and out_pending[p] <= 1 at the same edge, so both are visible the next cycle (latency 1).
  - Other ports are unaffected.
- Illegal accepted request:
  - No port state changes.
  - err_pulse=1 in the following cycle only.
  - err_count increments by 1, saturating at 255 (no wrap).
- Ack:
  - out_ack[p]=1 while out_pending[p]=1 clears out_pending[p] at that edge.
  - out_addr[p] keeps its value indefinitely, like a held modport signal.
  - out_ack[p] while out_pending[p]=0 is ignored.
- Ack and new legal request to the same port on the same edge: out_pending[p] stays 1 and out_addr[p] takes the new address.
- Ack on port p and a request to port q≠p on the same edge: both take effect independently.
- Back-to-back illegal requests: err_pulse stays high on consecutive cycles; err_count increments each cycle.
- No combinational path from in_addr to out_addr; outputs are registered.

Test Plan:
- Reset, then idle 3 cycles -> out_addr=0, out_pending=00, err_count=0, in_ready=1 with in_sel=0.
- Send addr 0x0000_1000 to sel 0, no ack -> next cycle out_addr[0]=0x1000, out_pending=01. A second request to sel 0 sees in_ready=0 until out_ack[0]=1.
- Send 0xDEAD_BEE0 to sel 1, assert out_ack[1] on the following cycle -> out_pending[1] clears; out_addr[1] stays 0xDEADBEE0 for 10 idle cycles.
- Port 0 pending; assert out_ack[0] together with a request 0x2000 to sel 0 -> in_ready=1, out_addr[0]=0x2000, out_pending[0] remains 1.
- Send misaligned 0x0000_1002 to sel 0 -> accepted, out_addr[0] unchanged, err_pulse=1 for one cycle, err_count=1. Then 300 consecutive misaligned requests -> err_count=255.
- Both ports pending; drive rst_n=0 for one cycle -> out_pending=00, out_addr=0, err_count=0 in the following cycle.
